// File: rtl/input_debounce_pkg.sv
// Shared types and constants for the input_debounce block.
package input_debounce_pkg;

    localparam int unsigned GLITCH_W = 8;
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    typedef enum logic [1:0] {
        STABLE_LOW,
        WAIT_HIGH,
        STABLE_HIGH,
        WAIT_LOW
    } state_t;

    // Saturating increment used by the rejected-transition counter.
    function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
        return (v == GLITCH_MAX) ? v : v + GLITCH_W'(1);
    endfunction

endpackage

// File: rtl/input_sync.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module input_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// Push-button/switch debouncer with glitch counter.
// Optional edge pulses enabled by defining INPUT_DEBOUNCE_EDGE_EN.
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                raw_in,
    input  logic                glitch_clr,
    output logic                level_out,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             glitch;

    input_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (raw_in),
        .dout   (sync_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= STABLE_LOW;
            cnt       <= '0;
            level_out <= 1'b0;
`ifdef INPUT_DEBOUNCE_EDGE_EN
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
`endif
        end else begin
`ifdef INPUT_DEBOUNCE_EDGE_EN
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
`endif
            unique case (state)
                STABLE_LOW: begin
                    if (sync_q) begin
                        state <= WAIT_HIGH;
                        cnt   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!sync_q) begin
                        state <= STABLE_LOW;
                    end else if (cnt == CNT_LAST) begin
                        state     <= STABLE_HIGH;
                        level_out <= 1'b1;
`ifdef INPUT_DEBOUNCE_EDGE_EN
                        rise_pulse <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STABLE_HIGH: begin
                    if (!sync_q) begin
                        state <= WAIT_LOW;
                        cnt   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (sync_q) begin
                        state <= STABLE_HIGH;
                    end else if (cnt == CNT_LAST) begin
                        state     <= STABLE_LOW;
                        level_out <= 1'b0;
`ifdef INPUT_DEBOUNCE_EDGE_EN
                        fall_pulse <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= STABLE_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifndef INPUT_DEBOUNCE_EDGE_EN
    assign rise_pulse = 1'b0;
    assign fall_pulse = 1'b0;
`endif

    // A glitch is the synchronized input reverting while a new level is pending.
    always_comb begin
        glitch = 1'b0;
        if (state == WAIT_HIGH && !sync_q) glitch = 1'b1;
        if (state == WAIT_LOW  &&  sync_q) glitch = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            glitch_cnt <= '0;
        end else if (glitch_clr) begin
            glitch_cnt <= '0;
        end else if (glitch) begin
            glitch_cnt <= sat_inc(glitch_cnt);
        end
    end

endmodule

// File: tb/tb_input_debounce.sv
// Directed, table-driven bench for input_debounce (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_input_debounce;

`ifdef INPUT_DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       raw_in;
    logic       glitch_clr;
    logic       level_out;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [7:0] glitch_cnt;

    int unsigned tests = 0;
    int unsigned fails = 0;

    typedef struct {
        logic       raw;
        logic       clr;
        logic       lvl;
        logic       rise;
        logic       fall;
        logic [7:0] gc;
    } vec_t;

    vec_t tbl[$];

    input_debounce #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .raw_in    (raw_in),
        .glitch_clr(glitch_clr),
        .level_out (level_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic raw, input logic clr, input logic lvl,
                                input logic rise, input logic fall, input logic [7:0] gc);
        vec_t v;
        v.raw = raw; v.clr = clr; v.lvl = lvl; v.rise = rise; v.fall = fall; v.gc = gc;
        tbl.push_back(v);
    endfunction

    task automatic glitch_once();
        raw_in = 1'b1; step();
        raw_in = 1'b0; step(); step(); step();
    endtask

    initial begin
        // Clean rise: accepted on the 7th edge after raw_in changes
        for (int i = 0; i < 6; i++) add(1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 1, 0, 0, 0);
        // Clean fall
        for (int i = 0; i < 6; i++) add(0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0);
        // High for 3 cycles then low: rejected, counted on the 6th edge
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0);
        // Rise again, then a one-cycle drop while high is rejected
        for (int i = 0; i < 6; i++) add(1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 2; i++) add(1, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) add(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 1, 0, 0, 1);

        reset_n    = 1'b0;
        raw_in     = 1'b0;
        glitch_clr = 1'b0;
        #12;
        chk("reset_level", {7'd0, level_out}, 8'd0);
        chk("reset_rise", {7'd0, rise_pulse}, 8'd0);
        chk("reset_fall", {7'd0, fall_pulse}, 8'd0);
        chk("reset_gcnt", glitch_cnt, 8'd0);
        #10;
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_level", {7'd0, level_out}, 8'd0);
            chk("idle_pulses", {6'd0, rise_pulse, fall_pulse}, 8'd0);
        end
        chk("idle_gcnt", glitch_cnt, 8'd0);

        foreach (tbl[i]) begin
            raw_in     = tbl[i].raw;
            glitch_clr = tbl[i].clr;
            step();
            chk($sformatf("vec%0d_level", i), {7'd0, level_out}, {7'd0, tbl[i].lvl});
            chk($sformatf("vec%0d_rise", i), {7'd0, rise_pulse}, {7'd0, tbl[i].rise & EDGE_EN});
            chk($sformatf("vec%0d_fall", i), {7'd0, fall_pulse}, {7'd0, tbl[i].fall & EDGE_EN});
            chk($sformatf("vec%0d_gcnt", i), glitch_cnt, tbl[i].gc);
        end
        glitch_clr = 1'b0;

        // Return low, then saturate the counter (starts at 1 here)
        raw_in = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("pre_sat_level", {7'd0, level_out}, 8'd0);
        chk("pre_sat_gcnt", glitch_cnt, 8'd1);
        for (int n = 1; n <= 300; n++) begin
            glitch_once();
            if (n == 253) chk("sat_253", glitch_cnt, 8'd254);
            if (n == 254) chk("sat_254", glitch_cnt, 8'd255);
        end
        chk("sat_300", glitch_cnt, 8'd255);
        chk("sat_level", {7'd0, level_out}, 8'd0);

        // Clear lands on the same edge as a glitch event: clear wins
        raw_in = 1'b1; step();
        raw_in = 1'b0; step(); step();
        glitch_clr = 1'b1; step();
        glitch_clr = 1'b0;
        chk("clr_vs_glitch", glitch_cnt, 8'd0);
        step();
        chk("clr_hold", glitch_cnt, 8'd0);

        // Reset during WAIT_HIGH with raw_in held high
        raw_in = 1'b1;
        for (int i = 0; i < 5; i++) step();
        #3;
        reset_n = 1'b0;
        #1;
        chk("midwait_level", {7'd0, level_out}, 8'd0);
        chk("midwait_rise", {7'd0, rise_pulse}, 8'd0);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rerise_wait_level", {7'd0, level_out}, 8'd0);
        end
        step();
        chk("rerise_level", {7'd0, level_out}, 8'd1);
        chk("rerise_pulse", {7'd0, rise_pulse}, {7'd0, EDGE_EN});
        step();
        chk("rerise_pulse_end", {7'd0, rise_pulse}, 8'd0);
        chk("rerise_hold", {7'd0, level_out}, 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/input_debounce.md
INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on raw_in (legal range 2..4).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, consecutive stable sync cycles required to accept a new level (minimum 1).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: port clk (input, 1, rising-edge clock) and port reset_n (input, 1, asynchronous active-low reset).
REQ-004 SHALL have port raw_in, input, 1 bit: asynchronous active-high push-button/switch level.
REQ-005 SHALL have port glitch_clr, input, 1 bit: synchronous clear of glitch_cnt.
REQ-006 SHALL have port level_out, output, 1 bit: registered debounced level; drives the downstream input PIO in_port.
REQ-007 SHALL have port rise_pulse, output, 1 bit: one-cycle pulse on an accepted 0->1 transition.
REQ-008 SHALL have port fall_pulse, output, 1 bit: one-cycle pulse on an accepted 1->0 transition.
REQ-009 SHALL have port glitch_cnt, output, 8 bits: saturating count of rejected transitions.

Function
REQ-010 SHALL pass raw_in through SYNC_STAGES flops; sync_q is the last stage.
REQ-011 SHALL implement FSM states STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
REQ-012 STABLE_LOW: sync_q=1 -> WAIT_HIGH, cnt<=0; else hold. STABLE_HIGH mirrors this: sync_q=0 -> WAIT_LOW.
REQ-013 WAIT_HIGH: sync_q=0 -> STABLE_LOW and glitch event; sync_q=1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HIGH, level_out<=1; otherwise cnt<=cnt+1. WAIT_LOW mirrors with level_out<=0.
REQ-014 Latency raw_in edge to level_out change SHALL be exactly SYNC_STAGES+DEBOUNCE_CYCLES+1 clocks for a clean edge.
REQ-015 rise_pulse/fall_pulse SHALL be high for exactly one cycle, in the same cycle level_out first shows the new value; never both high.
REQ-016 cnt width SHALL be $clog2(DEBOUNCE_CYCLES+1); cnt SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-017 glitch_cnt SHALL increment by 1 per glitch event and saturate at 255 (no wrap).
REQ-018 glitch_clr SHALL set glitch_cnt to 0 next cycle; on a simultaneous glitch event, clear wins (result 0).
REQ-019 A bounce that returns before acceptance SHALL leave level_out unchanged and produce no pulse.

Reset
REQ-020 On reset_n=0, asynchronously: sync flops 0, state STABLE_LOW, cnt 0, level_out 0, rise_pulse 0, fall_pulse 0, glitch_cnt 0.
REQ-021 Reset asserted mid-WAIT SHALL abandon the pending transition; after release, a held raw_in=1 SHALL require the full REQ-014 latency again.

Configuration
REQ-022 Macro INPUT_DEBOUNCE_EDGE_EN defined: rise_pulse/fall_pulse generated per REQ-015.
REQ-023 Macro undefined: rise_pulse and fall_pulse tied to 0, pulse registers not built; ports retained; all other behaviour identical.

Structure
REQ-024 Package input_debounce_pkg SHALL hold the FSM state typedef and constant GLITCH_W=8.
REQ-025 Synchronizer chain SHALL be sub-module input_sync (parameter STAGES), instantiated once.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-026 Reset, raw_in=0 held 20 cycles -> level_out=0, no pulses, glitch_cnt=0.
REQ-027 raw_in 0->1 clean -> level_out=1 and rise_pulse=1 exactly 7 clocks later, pulse width 1; then raw_in->0 -> fall_pulse after 7 clocks.
REQ-028 raw_in high 3 sync cycles then low -> level_out stays 0, glitch_cnt=1.
REQ-029 300 short glitches -> glitch_cnt=255; glitch_clr coinciding with a glitch -> glitch_cnt=0.
REQ-030 reset_n pulsed low during WAIT_HIGH with raw_in held 1 -> level_out=0 immediately, rises 7 clocks after release.
REQ-031 Build without INPUT_DEBOUNCE_EDGE_EN, repeat REQ-027 -> identical level_out timing, pulses constantly 0.
